ysyx_24110006_fetch: RTL and testbench

Instruction fetch unit for the multi-cycle NPC core: owns the PC, issues instruction reads to the instruction memory over a valid/ready read-address/read-data channel pair, and hands the fetched word plus its PC to the decode stage with a valid/ready handshake. Sits between the writeback stage, which supplies the next PC, and the decode stage, which consumes `o_inst`. One instruction is in flight at a time. A fetch may end in a memory access fault or a misaligned-PC fault; either is reported alongside the instruction.

---
 rtl/ysyx_24110006_fetch.sv | 110 +++++++++++
 tb/tb_ysyx_24110006_fetch.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110006_fetch.sv
// Instruction fetch unit: owns the PC, reads one instruction at a time over a
// valid/ready address/data channel pair, and offers it with its PC and fault code to decode.
module ysyx_24110006_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        i_clock,
  input  logic        i_rst_n,
  input  logic        i_next_valid,
  input  logic [31:0] i_next_pc,
  output logic [31:0] o_araddr,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic        i_rvalid,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  output logic        o_rready,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [1:0]  o_fault,
  output logic [31:0] o_fetch_cnt
);

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    OUT  = 3'd3,
    IDLE = 3'd4
  } state_t;

  localparam logic [1:0] FAULT_NONE   = 2'b00;
  localparam logic [1:0] FAULT_ACCESS = 2'b01;
  localparam logic [1:0] FAULT_ALIGN  = 2'b10;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  logic [1:0]  fault_reg, fault_next;
  logic [31:0] cnt_reg, cnt_next;

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_PC;
      inst_reg  <= 32'd0;
      fault_reg <= FAULT_NONE;
      cnt_reg   <= 32'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      inst_reg  <= inst_next;
      fault_reg <= fault_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    inst_next  = inst_reg;
    fault_next = fault_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      BOOT: state_next = AR;
      AR: begin
        if (i_arready) state_next = R;
      end
      R: begin
        if (i_rvalid) begin
          // The word is kept even on an access fault so decode can inspect it.
          inst_next  = i_rdata;
          fault_next = (i_rresp != 2'b00) ? FAULT_ACCESS : FAULT_NONE;
          state_next = OUT;
        end
      end
      OUT: begin
        if (i_inst_ready) begin
          cnt_next   = cnt_reg + 32'd1;
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (i_next_valid) begin
          pc_next = i_next_pc;
          // A misaligned target never reaches memory; the fault goes straight to decode.
          if (i_next_pc[1:0] != 2'b00) begin
            inst_next  = 32'd0;
            fault_next = FAULT_ALIGN;
            state_next = OUT;
          end else begin
            state_next = AR;
          end
        end
      end
      default: state_next = BOOT;
    endcase
  end

  assign o_arvalid    = (state_reg == AR);
  assign o_rready     = (state_reg == R);
  assign o_inst_valid = (state_reg == OUT);
  assign o_araddr     = pc_reg;
  assign o_pc         = pc_reg;
  assign o_inst       = inst_reg;
  assign o_fault      = fault_reg;
  assign o_fetch_cnt  = cnt_reg;

endmodule

// File: tb/tb_ysyx_24110006_fetch.sv
// Directed bench for the fetch unit: stimulus pushes expected deliveries into a
// scoreboard queue and a negedge monitor pops and checks every decode handshake.
module tb_ysyx_24110006_fetch;

  logic        i_clock = 1'b0;
  logic        i_rst_n;
  logic        i_next_valid;
  logic [31:0] i_next_pc;
  logic [31:0] o_araddr;
  logic        o_arvalid;
  logic        i_arready;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic [1:0]  i_rresp;
  logic        o_rready;
  logic        o_inst_valid;
  logic        i_inst_ready;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic [1:0]  o_fault;
  logic [31:0] o_fetch_cnt;

  ysyx_24110006_fetch dut (
    .i_clock      (i_clock),
    .i_rst_n      (i_rst_n),
    .i_next_valid (i_next_valid),
    .i_next_pc    (i_next_pc),
    .o_araddr     (o_araddr),
    .o_arvalid    (o_arvalid),
    .i_arready    (i_arready),
    .i_rvalid     (i_rvalid),
    .i_rdata      (i_rdata),
    .i_rresp      (i_rresp),
    .o_rready     (o_rready),
    .o_inst_valid (o_inst_valid),
    .i_inst_ready (i_inst_ready),
    .o_inst       (o_inst),
    .o_pc         (o_pc),
    .o_fault      (o_fault),
    .o_fetch_cnt  (o_fetch_cnt)
  );

  always #5 i_clock = ~i_clock;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  fault;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // Monitor: a handshake seen at negedge completes on the next rising edge.
  always @(negedge i_clock) begin
    if (i_rst_n && o_inst_valid && i_inst_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_delivery", {31'd0, o_inst_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("deliver_inst", o_inst, e.inst);
        chk("deliver_pc", o_pc, e.pc);
        chk("deliver_fault", {30'd0, o_fault}, {30'd0, e.fault});
        $display("deliver pc=%h inst=%h fault=%0d cnt=%0d", o_pc, o_inst, o_fault, o_fetch_cnt);
      end
    end
  end

  task automatic handshake();
    i_inst_ready = 1'b1;
    tick();
    i_inst_ready = 1'b0;
  endtask

  task automatic issue_next(input logic [31:0] pc);
    i_next_valid = 1'b1;
    i_next_pc    = pc;
    tick();
    i_next_valid = 1'b0;
  endtask

  logic [31:0] held_addr;

  initial begin
    i_rst_n = 1'b0; i_next_valid = 1'b0; i_next_pc = 32'd0;
    i_arready = 1'b1; i_rvalid = 1'b1; i_rdata = 32'h0000_0413;
    i_rresp = 2'b00; i_inst_ready = 1'b0;
    repeat (2) @(posedge i_clock);
    #1;
    chk("rst_arvalid", {31'd0, o_arvalid}, 32'd0);
    chk("rst_rready", {31'd0, o_rready}, 32'd0);
    chk("rst_inst_valid", {31'd0, o_inst_valid}, 32'd0);
    chk("rst_cnt", o_fetch_cnt, 32'd0);
    chk("rst_pc", o_pc, 32'h8000_0000);
    chk("rst_inst", o_inst, 32'd0);
    i_rst_n = 1'b1;

    // First fetch with a zero-wait memory.
    tick();
    chk("boot_arvalid", {31'd0, o_arvalid}, 32'd1);
    chk("boot_araddr", o_araddr, 32'h8000_0000);
    exp_q.push_back('{inst: 32'h0000_0413, pc: 32'h8000_0000, fault: 2'b00});
    tick();
    chk("lat1_inst_valid", {31'd0, o_inst_valid}, 32'd0);
    tick();
    chk("lat2_inst_valid", {31'd0, o_inst_valid}, 32'd1);
    handshake();
    chk("cnt_after_1", o_fetch_cnt, 32'd1);

    // Stalled address and data phases.
    i_arready = 1'b0; i_rvalid = 1'b0;
    issue_next(32'h8000_0004);
    exp_q.push_back('{inst: 32'h0010_0093, pc: 32'h8000_0004, fault: 2'b00});
    held_addr = o_araddr;
    for (int i = 0; i < 3; i++) begin
      chk("ar_stall_valid", {31'd0, o_arvalid}, 32'd1);
      chk("ar_stall_addr", o_araddr, 32'h8000_0004);
      tick();
    end
    i_arready = 1'b1;
    tick();
    i_arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("r_stall_rready", {31'd0, o_rready}, 32'd1);
      tick();
    end
    chk("r_stall_addr_held", o_araddr, held_addr);
    i_rdata = 32'h0010_0093; i_rvalid = 1'b1;
    tick();
    i_rvalid = 1'b0;
    chk("stall_inst_valid", {31'd0, o_inst_valid}, 32'd1);

    // Decode back-pressure with noisy inputs.
    for (int i = 0; i < 5; i++) begin
      i_rdata = 32'hA5A5_0000 + i; i_next_valid = i[0]; i_next_pc = 32'h9000_0000;
      tick();
      chk("bp_inst", o_inst, 32'h0010_0093);
      chk("bp_pc", o_pc, 32'h8000_0004);
      chk("bp_no_arvalid", {31'd0, o_arvalid}, 32'd0);
    end
    i_next_valid = 1'b0;
    handshake();
    chk("cnt_after_2", o_fetch_cnt, 32'd2);
    chk("idle_no_arvalid", {31'd0, o_arvalid}, 32'd0);

    // Misaligned next PC.
    issue_next(32'h8000_0006);
    exp_q.push_back('{inst: 32'd0, pc: 32'h8000_0006, fault: 2'b10});
    chk("mis_no_arvalid", {31'd0, o_arvalid}, 32'd0);
    chk("mis_inst_valid", {31'd0, o_inst_valid}, 32'd1);
    chk("mis_fault", {30'd0, o_fault}, 32'd2);
    handshake();

    // Access fault response.
    i_arready = 1'b1; i_rvalid = 1'b1; i_rresp = 2'b10; i_rdata = 32'hDEAD_BEEF;
    issue_next(32'h8000_0100);
    exp_q.push_back('{inst: 32'hDEAD_BEEF, pc: 32'h8000_0100, fault: 2'b01});
    tick(); tick();
    chk("acc_inst_valid", {31'd0, o_inst_valid}, 32'd1);
    handshake();
    i_rresp = 2'b00;
    chk("cnt_after_4", o_fetch_cnt, 32'd4);

    // Counter wrap via a preloaded count.
    force dut.cnt_reg = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_reg;
    i_rdata = 32'h0000_0013;
    issue_next(32'h8000_0200);
    exp_q.push_back('{inst: 32'h0000_0013, pc: 32'h8000_0200, fault: 2'b00});
    tick(); tick();
    chk("wrap_pre_cnt", o_fetch_cnt, 32'hFFFF_FFFF);
    handshake();
    chk("wrap_cnt", o_fetch_cnt, 32'd0);

    // Asynchronous reset during the data phase.
    i_rvalid = 1'b0;
    issue_next(32'h8000_0300);
    tick();
    chk("pre_rst_rready", {31'd0, o_rready}, 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_rready", {31'd0, o_rready}, 32'd0);
    chk("arst_arvalid", {31'd0, o_arvalid}, 32'd0);
    chk("arst_inst_valid", {31'd0, o_inst_valid}, 32'd0);
    chk("arst_cnt", o_fetch_cnt, 32'd0);
    chk("arst_pc", o_pc, 32'h8000_0000);
    tick();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
